// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module     : mem_arbiter_if
//  Description: Bundle of the two requester ports, the shared memory port
//               and the status outputs of the two-port memory arbiter.
//               The slave modport is the arbiter's view; the master modport
//               is the view of the surrounding requesters and memory.
//  Revision   : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 28,
    parameter int DW = 128
);
    // Port 0 (I-cache)
    logic          p0_read;
    logic          p0_write;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic [DW-1:0] p0_rdata;
    logic          p0_ready;

    // Port 1 (D-cache)
    logic          p1_read;
    logic          p1_write;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [DW-1:0] p1_rdata;
    logic          p1_ready;

    // Shared memory side
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Status
    logic [1:0]    grant;
    logic [31:0]   txn_count0;
    logic [31:0]   txn_count1;
    logic [31:0]   conflict_count;

    // Arbiter view
    modport slave (
        input  p0_read, p0_write, p0_addr, p0_wdata,
        output p0_rdata, p0_ready,
        input  p1_read, p1_write, p1_addr, p1_wdata,
        output p1_rdata, p1_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant, txn_count0, txn_count1, conflict_count
    );

    // Requester / memory view
    modport master (
        output p0_read, p0_write, p0_addr, p0_wdata,
        input  p0_rdata, p0_ready,
        output p1_read, p1_write, p1_addr, p1_wdata,
        input  p1_rdata, p1_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant, txn_count0, txn_count1, conflict_count
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : mem_arbiter
//  Description: Round-robin arbiter sharing one block memory between an
//               I-cache (port 0) and a D-cache (port 1). One transaction is
//               in flight at a time; each completion is followed by a single
//               dead cycle so requesters that register ready can release.
//  Revision   : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW = 28,
    parameter int DW = 128
) (
    input  logic         clk,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Controller state
    logic [1:0]    state_q,          state_d;
    logic [1:0]    grant_q,          grant_d;
    logic          last_q,           last_d;       // 1 = port 1 served last

    // Latched request of the current owner
    logic          op_write_q,       op_write_d;
    logic [AW-1:0] addr_q,           addr_d;
    logic [DW-1:0] wdata_q,          wdata_d;

    // Statistics
    logic [31:0]   txn_count0_q,     txn_count0_d;
    logic [31:0]   txn_count1_q,     txn_count1_d;
    logic [31:0]   conflict_count_q, conflict_count_d;

    // Decoded request / phase information
    logic          req0;
    logic          req1;
    logic          both_req;
    logic          pick1;
    logic          busy;
    logic          done;

    // Request decode and round-robin choice: on a tie the port not served
    // last wins, so neither cache can starve the other.
    always_comb begin
        req0     = bus.p0_read | bus.p0_write;
        req1     = bus.p1_read | bus.p1_write;
        both_req = req0 & req1;
        pick1    = req1 & (~req0 | ~last_q);
        busy     = (state_q == ST_BUSY);
        done     = busy & bus.mem_ready;
    end

    // Next-state logic for the controller, latch and counters
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        op_write_d       = op_write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        txn_count0_d     = txn_count0_q;
        txn_count1_d     = txn_count1_q;
        conflict_count_d = conflict_count_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_BUSY;
                    if (both_req) begin
                        conflict_count_d = conflict_count_q + 32'd1;
                    end
                    // Read+write together is a write: op follows the write bit.
                    if (pick1) begin
                        grant_d    = 2'b10;
                        op_write_d = bus.p1_write;
                        addr_d     = bus.p1_addr;
                        wdata_d    = bus.p1_wdata;
                    end else begin
                        grant_d    = 2'b01;
                        op_write_d = bus.p0_write;
                        addr_d     = bus.p0_addr;
                        wdata_d    = bus.p0_wdata;
                    end
                end
            end

            ST_BUSY: begin
                // The latch stays frozen until memory completes.
                if (bus.mem_ready) begin
                    state_d = ST_HOLD;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                    if (grant_q[0]) begin
                        txn_count0_d = txn_count0_q + 32'd1;
                    end
                    if (grant_q[1]) begin
                        txn_count1_d = txn_count1_q + 32'd1;
                    end
                end
            end

            ST_HOLD: begin
                // Requests are deliberately ignored for this one cycle.
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers with synchronous reset; a reset in BUSY drops the
    // transaction without completing it.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q          <= ST_IDLE;
            grant_q          <= 2'b00;
            last_q           <= 1'b1;
            op_write_q       <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            txn_count0_q     <= '0;
            txn_count1_q     <= '0;
            conflict_count_q <= '0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            last_q           <= last_d;
            op_write_q       <= op_write_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            txn_count0_q     <= txn_count0_d;
            txn_count1_q     <= txn_count1_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    // Memory strobes drop combinationally in the completion cycle so the
    // memory never sees a back-to-back duplicate request.
    assign bus.mem_read  = busy & ~bus.mem_ready & ~op_write_q;
    assign bus.mem_write = busy & ~bus.mem_ready &  op_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Completion is steered only to the owner; read data is zero otherwise.
    assign bus.p0_ready  = done & grant_q[0];
    assign bus.p1_ready  = done & grant_q[1];
    assign bus.p0_rdata  = (done & grant_q[0]) ? bus.mem_rdata : '0;
    assign bus.p1_rdata  = (done & grant_q[1]) ? bus.mem_rdata : '0;

    assign bus.grant          = grant_q;
    assign bus.txn_count0     = txn_count0_q;
    assign bus.txn_count1     = txn_count1_q;
    assign bus.conflict_count = conflict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : tb_mem_arbiter
//  Description: Self-checking bench for mem_arbiter: directed scenarios
//               followed by randomized requesters and memory latency, all
//               compared cycle by cycle against a transaction-level model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .RST(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns memory (-1 none), whether the post-completion
    // dead cycle is pending, who was served last, and the captured request.
    int            m_owner;
    bit            m_cool;
    int            m_last;
    bit            m_opw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [31:0]   m_cnt0, m_cnt1, m_conf;

    // Observations of the most recent cycle
    logic          obs_rd, obs_wr, obs_rdy0, obs_rdy1;
    logic [1:0]    obs_grant;
    logic [DW-1:0] obs_rdata0, obs_rdata1;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata;

    int wait_left;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_cool = 1'b0; m_last = 1; m_opw = 1'b0;
        m_addr = '0; m_wdata = '0; m_cnt0 = 0; m_cnt1 = 0; m_conf = 0;
    endtask

    // Compare every DUT output with what the model says this cycle shows.
    task automatic check_outputs();
        bit            own0, own1, done0, done1;
        logic [1:0]    g_exp;
        own0  = (m_owner == 0);
        own1  = (m_owner == 1);
        done0 = own0 && bus.mem_ready;
        done1 = own1 && bus.mem_ready;
        g_exp = own0 ? 2'b01 : (own1 ? 2'b10 : 2'b00);
        chk("mem_read",  bus.mem_read,  (own0 || own1) && !m_opw && !bus.mem_ready);
        chk("mem_write", bus.mem_write, (own0 || own1) &&  m_opw && !bus.mem_ready);
        chk("mem_addr",  bus.mem_addr,  m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("grant",     bus.grant,     g_exp);
        chk("p0_ready",  bus.p0_ready,  done0);
        chk("p1_ready",  bus.p1_ready,  done1);
        chk("p0_rdata",  bus.p0_rdata,  done0 ? bus.mem_rdata : '0);
        chk("p1_rdata",  bus.p1_rdata,  done1 ? bus.mem_rdata : '0);
        chk("txn_count0", bus.txn_count0, m_cnt0);
        chk("txn_count1", bus.txn_count1, m_cnt1);
        chk("conflict_count", bus.conflict_count, m_conf);
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        bit r0, r1;
        int pick;
        r0 = bus.p0_read || bus.p0_write;
        r1 = bus.p1_read || bus.p1_write;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (bus.mem_ready) begin
                if (m_owner == 0) m_cnt0 = m_cnt0 + 1;
                else              m_cnt1 = m_cnt1 + 1;
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1'b1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (r0 || r1) begin
            if (r0 && r1) begin
                pick   = 1 - m_last;
                m_conf = m_conf + 1;
            end else begin
                pick = r0 ? 0 : 1;
            end
            m_owner = pick;
            m_opw   = (pick == 0) ? bus.p0_write : bus.p1_write;
            m_addr  = (pick == 0) ? bus.p0_addr  : bus.p1_addr;
            m_wdata = (pick == 0) ? bus.p0_wdata : bus.p1_wdata;
        end
    endtask

    // One clock: check at the falling edge, then move past the rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        obs_rd     = bus.mem_read;
        obs_wr     = bus.mem_write;
        obs_rdy0   = bus.p0_ready;
        obs_rdy1   = bus.p1_ready;
        obs_rdata0 = bus.p0_rdata;
        obs_rdata1 = bus.p1_rdata;
        obs_grant  = bus.grant;
        obs_addr   = bus.mem_addr;
        obs_wdata  = bus.mem_wdata;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_read = rd; bus.p0_write = wr; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_read = rd; bus.p1_write = wr; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        wait_left = -1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Memory responder: random latency after a strobe, occasional stray ready.
    task automatic mem_drive(input bit allow_spurious);
        if (wait_left == 0) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = rand_blk(); wait_left = -1;
        end else if (wait_left > 0) begin
            wait_left = wait_left - 1; bus.mem_ready = 1'b0;
        end else begin
            bus.mem_ready = allow_spurious && ($urandom_range(0, 7) == 0);
            bus.mem_rdata = rand_blk();
        end
    endtask

    task automatic mem_observe();
        if (wait_left < 0 && (obs_rd || obs_wr)) wait_left = $urandom_range(0, 4);
    endtask

    initial begin
        int            nrd;
        int            order [4];
        int            k;
        int            st    [2];
        int            waitc [2];
        int            done_cnt [2];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] a5;

        model_reset();
        rst = 1'b1;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        wait_left = -1;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // Reset state
        chk("reset_grant", bus.grant, 2'b00);
        chk("reset_txn0", bus.txn_count0, 32'd0);
        chk("reset_conf", bus.conflict_count, 32'd0);

        // Single read with five wait cycles
        a5 = {16{8'hA5}};
        set_req(0, 1, 0, 28'h0000010, '0);
        tick();
        nrd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (obs_rd) nrd++;
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = a5;
        tick();
        chk("single_rd_cycles", nrd, 5);
        chk("single_rdy", obs_rdy0, 1'b1);
        chk("single_rdata", obs_rdata0, a5);
        chk("single_addr_held", obs_addr, 28'h0000010);
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        tick();
        chk("single_hold_grant", obs_grant, 2'b00);
        chk("single_hold_rd", obs_rd, 1'b0);
        set_req(0, 0, 0, '0, '0);
        tick();
        chk("single_txn0", bus.txn_count0, 32'd1);

        // Simultaneous requests right after reset: port 0 first
        do_reset();
        d = rand_blk();
        set_req(0, 1, 0, 28'h0000100, '0);
        set_req(1, 0, 1, 28'h0000200, d);
        tick();
        tick();
        chk("sim_first_grant", obs_grant, 2'b01);
        chk("sim_first_rd", obs_rd, 1'b1);
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = rand_blk();
        tick();
        chk("sim_p0_rdy", obs_rdy0, 1'b1);
        chk("sim_p1_not_rdy", obs_rdy1, 1'b0);
        bus.mem_ready = 1'b0;
        tick();
        chk("sim_gap1_wr", obs_wr, 1'b0);
        set_req(0, 0, 0, '0, '0);
        tick();
        chk("sim_gap2_wr", obs_wr, 1'b0);
        tick();
        chk("sim_p1_wr_start", obs_wr, 1'b1);
        chk("sim_p1_addr", obs_addr, 28'h0000200);
        chk("sim_p1_wdata", obs_wdata, d);
        // Granted port's inputs change mid-transaction; latch must not follow
        set_req(1, 0, 1, 28'h0000FFF, rand_blk());
        tick();
        chk("sim_latch_addr", obs_addr, 28'h0000200);
        chk("sim_latch_wdata", obs_wdata, d);
        bus.mem_ready = 1'b1;
        tick();
        chk("sim_p1_rdy", obs_rdy1, 1'b1);
        bus.mem_ready = 1'b0;
        tick();
        set_req(1, 0, 0, '0, '0);
        tick();
        chk("sim_conf", bus.conflict_count, 32'd1);
        chk("sim_txn0", bus.txn_count0, 32'd1);
        chk("sim_txn1", bus.txn_count1, 32'd1);

        // Round-robin with both ports held continuously
        do_reset();
        set_req(0, 1, 0, rand_addr(), '0);
        set_req(1, 1, 0, rand_addr(), '0);
        k = 0;
        for (int c = 0; c < 200 && k < 4; c++) begin
            mem_drive(1'b0);
            tick();
            mem_observe();
            if (obs_rdy0 || obs_rdy1) begin
                order[k] = obs_rdy1 ? 1 : 0;
                k++;
            end
        end
        chk("rr_done", k, 4);
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        bus.mem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);
        chk("rr_conf", bus.conflict_count, 32'd4);

        // Late release: request held during HOLD gives no second read
        do_reset();
        set_req(1, 1, 0, 28'h0000300, '0);
        tick();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        chk("late_rdy", obs_rdy1, 1'b1);
        bus.mem_ready = 1'b0;
        tick();
        set_req(1, 0, 0, '0, '0);
        nrd = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs_rd) nrd++;
        end
        chk("late_no_reissue", nrd, 0);
        chk("late_txn1", bus.txn_count1, 32'd1);

        // Abort: reset while port 1 is mid-write
        do_reset();
        set_req(1, 0, 1, 28'h0000400, rand_blk());
        tick();
        tick();
        chk("abort_wr_active", obs_wr, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1, 0, 0, '0, '0);
        tick();
        chk("abort_wr_low", obs_wr, 1'b0);
        chk("abort_no_rdy", obs_rdy1, 1'b0);
        chk("abort_txn1", bus.txn_count1, 32'd0);

        // Spurious ready while idle
        bus.mem_ready = 1'b1; bus.mem_rdata = rand_blk();
        tick();
        chk("spur_rdy0", obs_rdy0, 1'b0);
        chk("spur_rdy1", obs_rdy1, 1'b0);
        chk("spur_txn0", bus.txn_count0, 32'd0);
        bus.mem_ready = 1'b0;

        // Randomized traffic; requesters release one cycle after ready
        do_reset();
        for (int p = 0; p < 2; p++) begin
            st[p] = 0; waitc[p] = 0; done_cnt[p] = 0;
        end
        for (int c = 0; c < 700; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (c < 600 && st[p] == 0 && $urandom_range(0, 3) == 0) begin
                    st[p] = 1; waitc[p] = 0;
                    k = $urandom_range(0, 2);
                    set_req(p, k != 1, k != 0, rand_addr(), rand_blk());
                end else if (st[p] == 1 && $urandom_range(0, 3) == 0) begin
                    a = rand_addr(); d = rand_blk();
                    if (p == 0) begin bus.p0_addr = a; bus.p0_wdata = d; end
                    else        begin bus.p1_addr = a; bus.p1_wdata = d; end
                end
            end
            mem_drive(1'b1);
            tick();
            mem_observe();
            for (int p = 0; p < 2; p++) begin
                if (st[p] == 2) begin
                    st[p] = 0;
                    set_req(p, 0, 0, '0, '0);
                end else if (st[p] == 1) begin
                    waitc[p]++;
                    if ((p == 0) ? obs_rdy0 : obs_rdy1) begin
                        st[p] = 2;
                        done_cnt[p]++;
                        chk("service_bound", waitc[p] <= 20, 1'b1);
                    end
                end
            end
        end
        chk("rand_idle_at_end", (st[0] == 0) && (st[1] == 0), 1'b1);
        chk("rand_txn0_total", bus.txn_count0, done_cnt[0]);
        chk("rand_txn1_total", bus.txn_count1, done_cnt[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 28, meaning the word-block address width.
REQ-002 SHALL have parameter DW, default 128, meaning the block data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports p0_read, p0_write  input  1 each  port-0 (I-cache) read/write request, held until served.
REQ-006 SHALL have ports p0_addr  input  AW, and p0_wdata  input  DW  for the port-0 request address and write block.
REQ-007 SHALL have ports p0_rdata  output  DW, and p0_ready  output  1  for the port-0 read block and completion pulse.
REQ-008 SHALL have ports p1_read, p1_write, p1_addr, p1_wdata, p1_rdata, p1_ready with widths and meaning identical to port 0, for port 1 (D-cache).
REQ-009 SHALL have ports mem_read, mem_write  output  1 each, mem_addr  output  AW, and mem_wdata  output  DW  as the shared memory request.
REQ-010 SHALL have ports mem_rdata  input  DW, and mem_ready  input  1  as the memory read block and one-cycle completion pulse.
REQ-011 SHALL have port grant  output  2  one-hot owner of the memory (bit0 = port 0, bit1 = port 1), 2'b00 when idle.
REQ-012 SHALL have ports txn_count0, txn_count1  output  32 each  completed transactions per port.
REQ-013 SHALL have port conflict_count  output  32  number of arbitration decisions made with both ports requesting.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-015 IDLE: with no request, SHALL stay in IDLE with grant = 2'b00 and both memory strobes low.
REQ-016 IDLE: with one port requesting (read or write), SHALL grant that port and latch its op, addr and wdata, then move to BUSY on the next cycle.
REQ-017 IDLE: with both ports requesting, SHALL grant the port not granted last (round-robin), latch that port's request, increment conflict_count, and move to BUSY.
REQ-018 A port asserting read and write together SHALL be treated as a write.
REQ-019 BUSY: while mem_ready = 0, SHALL drive mem_read or mem_write (per the latched op), mem_addr and mem_wdata from the latched values.
REQ-020 BUSY: while mem_ready = 0, latched values SHALL NOT change, even if the granted port's inputs change.
REQ-021 BUSY with mem_ready = 1: SHALL deassert both strobes that cycle (combinationally gated).
REQ-022 BUSY with mem_ready = 1: SHALL pulse the granted port's pN_ready for that same cycle and pass mem_rdata to its pN_rdata.
REQ-023 BUSY with mem_ready = 1: SHALL increment that port's txn_count, record it as last granted, and move to HOLD.
REQ-024 HOLD: SHALL last exactly one cycle with both strobes low and grant = 2'b00, ignore both ports' requests, then return to IDLE; this absorbs the one-cycle-late release by requesters that register ready.
REQ-025 mem_ready asserted in IDLE or HOLD SHALL be ignored; no pN_ready pulse and no counter change.
REQ-026 The non-granted port SHALL see pN_ready = 0 and pN_rdata = 0 at all times.
REQ-027 The granted port SHALL see pN_rdata = mem_rdata only in the completion cycle and 0 otherwise.
REQ-028 Worst-case service delay for a held request SHALL be one full competing transaction plus one HOLD cycle; no starvation.
REQ-029 All counters SHALL wrap modulo 2^32.
REQ-030 mem_addr and mem_wdata SHALL hold the last latched values outside BUSY.

Reset
REQ-031 With RST = 1 at a posedge, the block SHALL enter IDLE and clear grant, txn_count0, txn_count1, conflict_count and the latched request.
REQ-032 Reset SHALL set the last-granted marker to port 1, so the first simultaneous request goes to port 0.
REQ-033 Reset asserted mid-BUSY SHALL abort the transaction: strobes low from the next cycle, no ready pulse, and no counter increment.

Verification
REQ-034 Single read: p0_read with addr 0x0000010, memory ready after 5 cycles with rdata 0xA5..A5 -> mem_read high 5 cycles, p0_ready 1 cycle with p0_rdata 0xA5..A5, txn_count0 = 1, HOLD then IDLE.
REQ-035 Simultaneous after reset: p0_read and p1_write same cycle -> port 0 served first, port 1 mem_write starts two cycles after port-0 completion, conflict_count = 1, counts 1/1.
REQ-036 Round-robin: both ports held requesting for 4 transactions -> grant order 0,1,0,1 and conflict_count = 4.
REQ-037 Late release: p1_read held one cycle past its p1_ready -> no second mem_read issued, txn_count1 = 1.
REQ-038 Abort: RST during BUSY for port 1 -> mem_write low next cycle, no p1_ready, txn_count1 = 0.
REQ-039 Spurious ready: mem_ready = 1 while IDLE -> p0_ready = p1_ready = 0 and counters unchanged.
